key_demux_buf: RTL and testbench

- Inverse of the key-selected multiplexer: one keyed input stream is steered to one of NR_CH output channels, selected by a KEY_LEN-bit key.
- Each channel buffers up to DEPTH words in its own FIFO with a valid/ready handshake, so slow consumers do not stall traffic bound for other channels.
- Sits between a single producer (e.g. keyboard scan decoder) and several per-function consumers (display, counters).

---
 rtl/key_demux_buf.sv | 89 ++++++++
 tb/tb_key_demux_buf.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/key_demux_buf.sv
// Key-addressed demultiplexer: steers one keyed input stream into NR_CH independent FIFOs.
// Optional macro KEY_DEMUX_DEFAULT_CH_EN routes miss keys to channel NR_CH-1 instead of dropping them.
module key_demux_buf #(
  parameter int unsigned NR_CH    = 4,
  parameter int unsigned KEY_LEN  = 2,
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [KEY_LEN-1:0]                      in_key,
  input  logic [DATA_LEN-1:0]                     in_data,
  output logic [NR_CH-1:0]                        out_valid,
  input  logic [NR_CH-1:0]                        out_ready,
  output logic [NR_CH*DATA_LEN-1:0]               out_data,
  output logic [NR_CH*($clog2(DEPTH)+1)-1:0]      out_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic               w_hit;
  logic               w_route;
  logic [KEY_LEN-1:0] w_dst;
  logic [NR_CH-1:0]   w_full;
  logic [NR_CH-1:0]   w_push;
  logic [NR_CH-1:0]   w_pop;

  assign w_hit = (32'(in_key) < NR_CH);

  // Destination decode; w_route low means the word is accepted and discarded
  always_comb begin
    w_route = w_hit;
    w_dst   = in_key;
`ifdef KEY_DEMUX_DEFAULT_CH_EN
    if (!w_hit) begin
      w_route = 1'b1;
      w_dst   = KEY_LEN'(NR_CH - 1);
    end
`endif
  end

  // in_ready depends only on the key and registered full flags, never on out_ready
  always_comb begin
    in_ready = 1'b1;
    for (int unsigned i = 0; i < NR_CH; i++) begin
      if (w_route && (w_dst == KEY_LEN'(i))) in_ready = !w_full[i];
    end
  end

  for (genvar g = 0; g < NR_CH; g++) begin : g_ch
    logic [DATA_LEN-1:0] r_mem [DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;

    assign w_push[g]    = in_valid && in_ready && w_route && (w_dst == KEY_LEN'(g));
    assign w_full[g]    = (r_count == CW'(DEPTH));
    assign out_valid[g] = (r_count != '0);
    assign w_pop[g]     = out_valid[g] && out_ready[g];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop[g])  r_rd_ptr <= r_rd_ptr + PW'(1);
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage needs no reset: an empty channel masks its head to zero
    always_ff @(posedge clk) begin
      if (w_push[g] && !rst) r_mem[r_wr_ptr] <= in_data;
    end

    assign out_data[g*DATA_LEN +: DATA_LEN] = out_valid[g] ? r_mem[r_rd_ptr] : '0;
    assign out_count[g*CW +: CW]            = r_count;
  end

endmodule

// File: tb/tb_key_demux_buf.sv
// Scoreboard bench for key_demux_buf (NR_CH=4, KEY_LEN=3 so keys 4..7 are misses).
// Honours KEY_DEMUX_DEFAULT_CH_EN the same way as the design build.
module tb_key_demux_buf;
  localparam int NR_CH    = 4;
  localparam int KEY_LEN  = 3;
  localparam int DATA_LEN = 8;
  localparam int DEPTH    = 2;
  localparam int CW       = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [KEY_LEN-1:0]        in_key;
  logic [DATA_LEN-1:0]       in_data;
  logic [NR_CH-1:0]          out_valid;
  logic [NR_CH-1:0]          out_ready;
  logic [NR_CH*DATA_LEN-1:0] out_data;
  logic [NR_CH*CW-1:0]       out_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb_q [NR_CH][$];  // expected pop order, consumed by the monitor
  logic [7:0] m_q  [NR_CH][$];  // reference FIFO contents

  key_demux_buf #(.NR_CH(NR_CH), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dst_of(input int key);
    if (key < NR_CH) return key;
`ifdef KEY_DEMUX_DEFAULT_CH_EN
    return NR_CH - 1;
`else
    return -1;
`endif
  endfunction

  task automatic check_state();
    for (int ch = 0; ch < NR_CH; ch++) begin
      chk($sformatf("out_valid[%0d]", ch), int'(out_valid[ch]), (m_q[ch].size() != 0) ? 1 : 0);
      chk($sformatf("out_count[%0d]", ch), int'(out_count[ch*CW +: CW]), m_q[ch].size());
      chk($sformatf("out_data[%0d]", ch), int'(out_data[ch*DATA_LEN +: DATA_LEN]),
          (m_q[ch].size() != 0) ? int'(m_q[ch][0]) : 0);
    end
  endtask

  // One clock of stimulus: called just after a rising edge, returns just after the next one
  task automatic cycle(input logic v, input int key, input logic [7:0] d, input logic [3:0] rdy);
    int dst;
    bit exp_rdy;
    bit acc;
    in_valid  = v;
    in_key    = 3'(key);
    in_data   = d;
    out_ready = rdy;
    #1;
    dst     = dst_of(key);
    exp_rdy = (dst < 0) ? 1'b1 : (m_q[dst].size() < DEPTH);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    acc = v && exp_rdy;
    if (acc && dst >= 0) sb_q[dst].push_back(d);
    @(posedge clk);
    #1;
    for (int ch = 0; ch < NR_CH; ch++)
      if (m_q[ch].size() != 0 && rdy[ch]) void'(m_q[ch].pop_front());
    if (acc && dst >= 0) m_q[dst].push_back(d);
    check_state();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_key    = 3'd2;
    in_data   = 8'hEE;
    out_ready = '0;
    for (int ch = 0; ch < NR_CH; ch++) begin
      m_q[ch].delete();
      sb_q[ch].delete();
    end
    #1;
    check_state();
    chk("in_ready_rst", int'(in_ready), 1);
    @(posedge clk);
    #1;
    check_state();
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  // Monitor: every head presented is compared with the scoreboard, popped on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int ch = 0; ch < NR_CH; ch++) begin
          if (out_valid[ch]) begin
            if (sb_q[ch].size() == 0) begin
              n_vec++;
              n_err++;
              $display("FAIL sb_head[%0d]: got %0h with nothing expected", ch,
                       out_data[ch*DATA_LEN +: DATA_LEN]);
            end else begin
              chk($sformatf("sb_head[%0d]", ch), int'(out_data[ch*DATA_LEN +: DATA_LEN]),
                  int'(sb_q[ch][0]));
              if (out_ready[ch]) void'(sb_q[ch].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_key = '0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    chk("in_ready_reset", int'(in_ready), 1);
    rst = 1'b0;

    // Single word to channel 1, then pop
    cycle(1'b1, 1, 8'hA5, 4'b0000);
    chk("ch1_data_a5", int'(out_data[15:8]), 'hA5);
    cycle(1'b0, 0, 8'h00, 4'b0010);

    // Fill channel 3, third offer refused, then FIFO order and refill
    cycle(1'b1, 3, 8'h11, 4'b0000);
    cycle(1'b1, 3, 8'h22, 4'b0000);
    cycle(1'b1, 3, 8'h33, 4'b0000);
    chk("ch3_count_full", int'(out_count[7:6]), 2);
    cycle(1'b0, 0, 8'h00, 4'b1000);
    cycle(1'b1, 3, 8'h33, 4'b0000);
    repeat (3) cycle(1'b0, 0, 8'h00, 4'b1000);

    // Full channel 0: pop and push together, push refused (no pass-through)
    cycle(1'b1, 0, 8'h01, 4'b0000);
    cycle(1'b1, 0, 8'h02, 4'b0000);
    cycle(1'b1, 0, 8'h03, 4'b0001);
    cycle(1'b1, 0, 8'h03, 4'b0000);
    chk("ch0_count_refill", int'(out_count[1:0]), 2);
    repeat (2) cycle(1'b0, 0, 8'h00, 4'b0001);

    // One word in channel 0: simultaneous push and pop keeps count at 1
    cycle(1'b1, 0, 8'h55, 4'b0000);
    cycle(1'b1, 0, 8'h44, 4'b0001);
    chk("ch0_head_44", int'(out_data[7:0]), 'h44);
    cycle(1'b0, 0, 8'h00, 4'b0001);

    // Miss key
    cycle(1'b1, 5, 8'h7E, 4'b0000);
    cycle(1'b0, 0, 8'h00, 4'b1111);

    // Push to an empty channel with out_ready high: no pop that cycle
    cycle(1'b1, 2, 8'h9C, 4'b0100);
    cycle(1'b0, 0, 8'h00, 4'b0100);

    // Mid-run reset with channel 2 holding two words
    cycle(1'b1, 2, 8'hC1, 4'b0000);
    cycle(1'b1, 2, 8'hC2, 4'b0000);
    do_reset();

    // Random traffic
    for (int n = 0; n < 1500; n++)
      cycle(1'($urandom), int'($urandom_range(0, 7)), 8'($urandom), 4'($urandom));

    repeat (4) cycle(1'b0, 0, 8'h00, 4'b1111);
    for (int ch = 0; ch < NR_CH; ch++)
      chk($sformatf("sb_drained[%0d]", ch), sb_q[ch].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
